// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus: control-unit strobes, ROM port and the instruction word handed downstream.
interface inst_fetch_unit_if #(
  parameter int ADDR_W = 10,
  parameter int INST_W = 32,
  parameter int CNT_W  = 16
);
  logic              CPU_EN;
  logic              ROM_CLKEN;
  logic              PC_REG_EN;
  logic              PC_SRC_SEL;
  logic [ADDR_W-1:0] BRANCH_TARGET;
  logic [INST_W-1:0] ROM_DATA;
  logic [ADDR_W-1:0] ROM_ADDR;
  logic [INST_W-1:0] INSTRUCTION;
  logic              INST_VALID;
  logic [ADDR_W-1:0] INST_PC;
  logic [ADDR_W-1:0] PC_NEXT;
  logic [CNT_W-1:0]  FETCH_COUNT;

  modport master (
    output CPU_EN, ROM_CLKEN, PC_REG_EN, PC_SRC_SEL, BRANCH_TARGET, ROM_DATA,
    input  ROM_ADDR, INSTRUCTION, INST_VALID, INST_PC, PC_NEXT, FETCH_COUNT
  );

  modport slave (
    input  CPU_EN, ROM_CLKEN, PC_REG_EN, PC_SRC_SEL, BRANCH_TARGET, ROM_DATA,
    output ROM_ADDR, INSTRUCTION, INST_VALID, INST_PC, PC_NEXT, FETCH_COUNT
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, drives the sync ROM, latches one word per fetch
// and squashes a fetch overtaken by a taken branch in its data cycle.
module inst_fetch_unit #(
  parameter int                ADDR_W   = 10,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input logic               CLK,
  input logic               ASYS_CLR,
  inst_fetch_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT_DATA, VALID} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_inc, fetch_pc, fetch_pc_n, inst_pc;
  logic [INST_W-1:0] instruction;
  logic [CNT_W-1:0]  fetch_count;
  logic              inst_valid, squash, squash_n;
  logic              kill, capture, drop, consume;

  assign pc_inc           = pc + ADDR_W'(1);
  assign bus.ROM_ADDR     = pc;
  assign bus.PC_NEXT      = pc_inc;
  assign bus.INSTRUCTION  = instruction;
  assign bus.INST_VALID   = inst_valid;
  assign bus.INST_PC      = inst_pc;
  assign bus.FETCH_COUNT  = fetch_count;

  // A taken branch during the data cycle makes the in-flight word stale.
  assign kill = squash | (bus.PC_REG_EN & bus.PC_SRC_SEL);

  always_comb begin
    state_n    = state;
    squash_n   = squash;
    fetch_pc_n = fetch_pc;
    capture    = 1'b0;
    drop       = 1'b0;
    consume    = 1'b0;
    case (state)
      WAIT_DATA: begin
        if (kill) begin
          drop     = 1'b1;
          squash_n = 1'b1;
          state_n  = IDLE;
        end else begin
          capture  = 1'b1;
          state_n  = VALID;
        end
        if (bus.ROM_CLKEN) begin
          fetch_pc_n = pc;
          squash_n   = 1'b0;
          state_n    = WAIT_DATA;
        end
      end
      default: begin
        if (bus.ROM_CLKEN) begin
          fetch_pc_n = pc;
          squash_n   = 1'b0;
          state_n    = WAIT_DATA;
        end else if (state == VALID && bus.PC_REG_EN) begin
          consume = 1'b1;
          state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge ASYS_CLR) begin
    if (!ASYS_CLR) begin
      state    <= IDLE;
      squash   <= 1'b0;
      fetch_pc <= '0;
      pc       <= RESET_PC;
    end else if (bus.CPU_EN) begin
      state    <= state_n;
      squash   <= squash_n;
      fetch_pc <= fetch_pc_n;
      if (bus.PC_REG_EN)
        pc <= bus.PC_SRC_SEL ? bus.BRANCH_TARGET : pc_inc;
    end
  end

  always_ff @(posedge CLK or negedge ASYS_CLR) begin
    if (!ASYS_CLR) begin
      instruction <= '0;
      inst_pc     <= '0;
      inst_valid  <= 1'b0;
      fetch_count <= '0;
    end else if (bus.CPU_EN) begin
      if (capture) begin
        instruction <= bus.ROM_DATA;
        inst_pc     <= fetch_pc;
        inst_valid  <= 1'b1;
        if (fetch_count != '1)
          fetch_count <= fetch_count + CNT_W'(1);
      end else if (drop || consume) begin
        inst_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: vector table plus freeze, wrap, reset and saturation sequences.
module tb_inst_fetch_unit;
  logic CLK = 1'b0;
  logic ASYS_CLR;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 CLK = ~CLK;

  inst_fetch_unit_if #(.ADDR_W(10), .INST_W(32), .CNT_W(16)) bus ();
  inst_fetch_unit_if #(.ADDR_W(10), .INST_W(32), .CNT_W(4))  bus_s ();

  inst_fetch_unit #(.ADDR_W(10), .INST_W(32), .RESET_PC(10'd0), .CNT_W(16)) dut (
    .CLK(CLK), .ASYS_CLR(ASYS_CLR), .bus(bus));
  inst_fetch_unit #(.ADDR_W(10), .INST_W(32), .RESET_PC(10'd0), .CNT_W(4)) dut_s (
    .CLK(CLK), .ASYS_CLR(ASYS_CLR), .bus(bus_s));

  assign bus_s.CPU_EN        = bus.CPU_EN;
  assign bus_s.ROM_CLKEN     = bus.ROM_CLKEN;
  assign bus_s.PC_REG_EN     = bus.PC_REG_EN;
  assign bus_s.PC_SRC_SEL    = bus.PC_SRC_SEL;
  assign bus_s.BRANCH_TARGET = bus.BRANCH_TARGET;
  assign bus_s.ROM_DATA      = bus.ROM_DATA;

  // Synchronous ROM: ROM[n] = 0xE000_0000 + n, output held while clken is low.
  always @(posedge CLK)
    if (bus.ROM_CLKEN) bus.ROM_DATA <= 32'hE000_0000 + {22'd0, bus.ROM_ADDR};

  function automatic logic [31:0] rom(input int a);
    return 32'hE000_0000 + a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic en, input logic ce, input logic re, input logic ss,
                       input logic [9:0] tgt);
    bus.CPU_EN = en; bus.ROM_CLKEN = ce; bus.PC_REG_EN = re;
    bus.PC_SRC_SEL = ss; bus.BRANCH_TARGET = tgt;
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [31:0] ins,
                         input logic [9:0] ipc, input logic [9:0] pc, input logic [15:0] cnt);
    chk({tag, ".valid"}, bus.INST_VALID, v);
    chk({tag, ".inst"},  bus.INSTRUCTION, ins);
    chk({tag, ".ipc"},   bus.INST_PC, ipc);
    chk({tag, ".pc"},    bus.ROM_ADDR, pc);
    chk({tag, ".cnt"},   bus.FETCH_COUNT, cnt);
  endtask

  typedef struct {
    logic        ce, re, ss;
    logic [9:0]  tgt;
    logic        v;
    logic [31:0] ins;
    logic [9:0]  ipc, pc;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt[17];

  initial begin
    // sequential fetch, alternating ROM_CLKEN / PC_REG_EN
    vt[0]  = '{1,0,0,10'h0,  0, 32'h0,   10'd0, 10'd0, 16'd0};
    vt[1]  = '{0,1,0,10'h0,  1, rom(0),  10'd0, 10'd1, 16'd1};
    vt[2]  = '{1,0,0,10'h0,  1, rom(0),  10'd0, 10'd1, 16'd1};
    vt[3]  = '{0,1,0,10'h0,  1, rom(1),  10'd1, 10'd2, 16'd2};
    vt[4]  = '{1,0,0,10'h0,  1, rom(1),  10'd1, 10'd2, 16'd2};
    vt[5]  = '{0,1,0,10'h0,  1, rom(2),  10'd2, 10'd3, 16'd3};
    vt[6]  = '{1,0,0,10'h0,  1, rom(2),  10'd2, 10'd3, 16'd3};
    vt[7]  = '{0,1,0,10'h0,  1, rom(3),  10'd3, 10'd4, 16'd4};
    // consume and advance to PC=5
    vt[8]  = '{0,1,0,10'h0,  0, rom(3),  10'd3, 10'd5, 16'd4};
    // back-to-back from PC=5
    vt[9]  = '{1,1,0,10'h0,  0, rom(3),  10'd3, 10'd6, 16'd4};
    vt[10] = '{1,1,0,10'h0,  1, rom(5),  10'd5, 10'd7, 16'd5};
    vt[11] = '{1,1,0,10'h0,  1, rom(6),  10'd6, 10'd8, 16'd6};
    vt[12] = '{0,0,0,10'h0,  1, rom(7),  10'd7, 10'd8, 16'd7};
    // fetch at PC=8 squashed by branch to 0x20
    vt[13] = '{1,0,0,10'h0,  1, rom(7),  10'd7, 10'd8, 16'd7};
    vt[14] = '{0,1,1,10'h20, 0, rom(7),  10'd7, 10'h20, 16'd7};
    vt[15] = '{1,0,0,10'h0,  0, rom(7),  10'd7, 10'h20, 16'd7};
    vt[16] = '{0,0,0,10'h0,  1, rom(32), 10'h20, 10'h20, 16'd8};

    drive(1, 0, 0, 0, 10'h0);
    ASYS_CLR = 1'b0;
    repeat (2) step();
    chk_all("reset", 0, 32'h0, 10'd0, 10'd0, 16'd0);
    ASYS_CLR = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(1, vt[i].ce, vt[i].re, vt[i].ss, vt[i].tgt);
      step();
      chk_all($sformatf("vec%0d", i), vt[i].v, vt[i].ins, vt[i].ipc, vt[i].pc, vt[i].cnt);
    end

    // PC wrap via branch to 0x3FF then increment
    drive(1, 0, 1, 1, 10'h3FF);
    step();
    chk("wrap.pc_top", bus.ROM_ADDR, 10'h3FF);
    chk("wrap.pc_next", bus.PC_NEXT, 10'h000);
    chk("wrap.consumed", bus.INST_VALID, 1'b0);
    drive(1, 0, 1, 0, 10'h0);
    step();
    chk("wrap.pc_zero", bus.ROM_ADDR, 10'h000);
    chk("wrap.pc_next1", bus.PC_NEXT, 10'h001);

    // launch at PC=0 then freeze 3 cycles with strobes that must be ignored
    drive(1, 1, 0, 0, 10'h0);
    step();
    drive(0, 0, 1, 1, 10'h155);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("freeze%0d", i), 0, rom(32), 10'h20, 10'd0, 16'd8);
    end
    drive(1, 0, 0, 0, 10'h0);
    step();
    chk_all("thaw", 1, rom(0), 10'd0, 10'd0, 16'd9);

    // launch with PC advance, then reset in WAIT_DATA
    drive(1, 1, 1, 0, 10'h0);
    step();
    chk_all("prereset", 1, rom(0), 10'd0, 10'd1, 16'd9);
    drive(1, 0, 0, 0, 10'h0);
    #2 ASYS_CLR = 1'b0;
    #1;
    chk_all("midreset", 0, 32'h0, 10'd0, 10'd0, 16'd0);
    #1 ASYS_CLR = 1'b1;
    step();
    chk_all("postreset", 0, 32'h0, 10'd0, 10'd0, 16'd0);

    // 20 back-to-back fetches: narrow counter saturates at 15
    drive(1, 1, 1, 0, 10'h0);
    repeat (20) step();
    drive(1, 0, 0, 0, 10'h0);
    step();
    chk("sat.cnt16", bus.FETCH_COUNT, 16'd20);
    chk("sat.cnt4", bus_s.FETCH_COUNT, 4'd15);
    chk("sat.inst", bus.INSTRUCTION, rom(19));
    drive(1, 1, 0, 0, 10'h0);
    step();
    drive(1, 0, 0, 0, 10'h0);
    step();
    chk("sat.hold", bus_s.FETCH_COUNT, 4'd15);
    chk("sat.cnt16b", bus.FETCH_COUNT, 16'd21);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Front-end stage directly upstream of the processor control unit.
- Owns the program counter and drives the instruction-ROM address.
- Captures the synchronous ROM read data into an instruction register and presents a stable INSTRUCTION word, with a valid flag and its PC, to the control unit.
- Obeys the control unit's ROM_CLKEN, PC_REG_EN and PC_SRC_SEL strobes, and squashes fetches made stale by a taken branch.

Parameters:
- ADDR_W, 10: ROM word-address / PC width.
- INST_W, 32: instruction width.
- RESET_PC, 0: PC value loaded on reset.
- CNT_W, 16: width of the fetch performance counter.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- ASYS_CLR  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- CPU_EN  in  1  global run enable; 0 freezes all state except reset.
- ROM_CLKEN  in  1  from control unit; ROM samples ROM_ADDR at this edge.
- PC_REG_EN  in  1  from control unit; advance or load the PC this edge.
- PC_SRC_SEL  in  1  0 = PC+1, 1 = BRANCH_TARGET.
- BRANCH_TARGET  in  ADDR_W  branch destination word address.
- ROM_DATA  in  INST_W  ROM read data, valid one cycle after the sampling edge.
- ROM_ADDR  out  ADDR_W  equal to the PC register (combinational from the register).
- INSTRUCTION  out  INST_W  instruction register contents.
- INST_VALID  out  1  INSTRUCTION holds a non-squashed fetched word.
- INST_PC  out  ADDR_W  word address INSTRUCTION was fetched from.
- PC_NEXT  out  ADDR_W  PC+1 modulo 2^ADDR_W, combinational.
- FETCH_COUNT  out  CNT_W  number of completed, non-squashed fetches (saturating).

Behaviour:
- Reset (ASYS_CLR = 0, asynchronous):
  - PC = RESET_PC, INSTRUCTION = 0, INST_VALID = 0, INST_PC = 0, FETCH_COUNT = 0.
  - State = IDLE; the squash bit and the pending fetch PC are cleared.
  - A reset during WAIT_DATA discards the in-flight word.
- When CPU_EN = 0, every register holds and strobes are ignored. A pending ROM word stays pending and is captured on the first edge with CPU_EN = 1. The ROM's output is assumed held while its clock enable is low.
- PC update, at an edge with CPU_EN & PC_REG_EN:
  - PC <= PC_SRC_SEL ? BRANCH_TARGET : PC + 1.
  - The increment wraps, so 2^ADDR_W − 1 goes to 0.
- Fetch state machine (advances only when CPU_EN = 1):
  - IDLE / VALID, with ROM_CLKEN = 1:
    - fetch_pc <= PC (the pre-update value when PC_REG_EN is asserted at the same edge).
    - squash <= 0; go to WAIT_DATA.
  - WAIT_DATA: at the next edge, if squash = 0:
    - INSTRUCTION <= ROM_DATA, INST_PC <= fetch_pc, INST_VALID <= 1, FETCH_COUNT += 1.
    - Go to VALID.
    - If ROM_CLKEN is also 1 at this edge, start a new fetch and stay in WAIT_DATA (back-to-back fetch, 1 word per cycle).
  - WAIT_DATA with squash = 1: the data is dropped, INST_VALID <= 0, FETCH_COUNT is unchanged, and the next state is IDLE (or WAIT_DATA if ROM_CLKEN = 1).
  - VALID with PC_REG_EN = 1 and no ROM_CLKEN: INST_VALID <= 0, go to IDLE. The instruction is consumed; INSTRUCTION and INST_PC keep their value.
- Squash rule:
  - PC_REG_EN & PC_SRC_SEL at the launch edge does not squash, because the fetch uses the old PC by definition.
  - PC_REG_EN & PC_SRC_SEL in the cycle after launch (while in WAIT_DATA) sets squash; the capture edge then discards the word.
- Latency: ROM_CLKEN edge → INSTRUCTION / INST_VALID update one edge later (1-cycle fetch latency).
- FETCH_COUNT saturates at 2^CNT_W − 1 and never wraps.
- ROM_ADDR changes only on PC edges and is glitch-free (register output).

Test Plan:
- Reset then sequential fetch:
  - Stimulus: ASYS_CLR low then high, RESET_PC = 0, ROM[n] = 0xE000_0000 + n; pulse ROM_CLKEN then PC_REG_EN (PC_SRC_SEL = 0) alternately for 4 instructions.
  - Required: INST_PC = 0, 1, 2, 3; INSTRUCTION = 0xE000_0000 … 0xE000_0003; FETCH_COUNT = 4.
- Back-to-back fetch:
  - Stimulus: ROM_CLKEN and PC_REG_EN both held at 1 for 3 cycles from PC = 5.
  - Required: INSTRUCTION = ROM[5], ROM[6], ROM[7] on consecutive edges; INST_VALID stays 1.
- Taken branch squash:
  - Stimulus: launch a fetch at PC = 8; next cycle PC_REG_EN = 1, PC_SRC_SEL = 1, BRANCH_TARGET = 0x20.
  - Required: ROM[8] is not captured, INST_VALID = 0, FETCH_COUNT unchanged, PC = 0x20; the next fetch returns ROM[0x20] with INST_PC = 0x20.
- PC wrap:
  - Stimulus: load BRANCH_TARGET = 0x3FF, then increment.
  - Required: PC goes 0x3FF → 0x000; PC_NEXT = 0x000 while PC = 0x3FF.
- CPU_EN freeze and mid-fetch reset:
  - Stimulus: drop CPU_EN in WAIT_DATA for 3 cycles.
  - Required: all outputs hold; capture occurs on the first enabled edge.
  - Stimulus: assert ASYS_CLR low in WAIT_DATA.
  - Required: immediately INST_VALID = 0, PC = RESET_PC, FETCH_COUNT = 0; the word is not captured after release.
- Counter saturation:
  - Stimulus: CNT_W = 4; perform 20 fetches.
  - Required: FETCH_COUNT = 15 and holds.
